// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the RV32I multicycle control FSM and its datapath.
// master = control FSM side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;

  logic        pc_write;
  logic        adr_src;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  imm_src;
  logic [1:0]  alu_op;
  logic        illegal;

  modport master (
    input  instr, zero, mem_ready,
    output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_op, illegal
  );

  modport slave (
    output instr, zero, mem_ready,
    input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_op, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the RV32I multicycle core; one state per datapath cycle.
// Define PERF_CNT_EN to build the retired-instruction counter (retired_o tied to 0 otherwise).
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 when memory completes
// DECODE | decode opcode, ALUOut <= branch target
// MEMADR | ALUOut <= rs1 + imm for lw/sw
// MEMRD  | load data read at ALUOut
// MEMWB  | write load data to rd
// MEMWR  | store to ALUOut, held until memory completes
// EXER   | R-type ALU op
// EXEI   | I-type ALU op
// EXEU   | lui / auipc
// ALUWB  | write ALUOut to rd
// BRANCH | compare rs1/rs2, redirect PC to branch target if taken
// JALR   | ALUOut <= rs1 + imm, then shares JAL
// JAL    | PC <= ALUOut, ALUOut <= OldPC+4
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus,
  output logic [CNT_W-1:0]   retired_o
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXER   = 4'd6,
    EXEI   = 4'd7,
    EXEU   = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10,
    JALR   = 4'd11,
    JAL    = 4'd12
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  opcode;
  logic        funct3_lsb;
  logic        unused_instr;

  assign opcode       = bus.instr[6:0];
  assign funct3_lsb   = bus.instr[12];
  assign unused_instr = ^{bus.instr[31:15], bus.instr[14:13], bus.instr[11:7]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:       state_d = MEMADR;
          OP_R:               state_d = EXER;
          OP_I:               state_d = EXEI;
          OP_BR:              state_d = BRANCH;
          OP_JAL:             state_d = JAL;
          OP_JALR:            state_d = JALR;
          OP_LUI, OP_AUIPC:   state_d = EXEU;
          default:            state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_SW)      state_d = MEMWR;
        else if (opcode == OP_LW) state_d = MEMRD;
        else                      state_d = FETCH;
      end
      MEMRD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (bus.mem_ready) state_d = FETCH;
      EXER, EXEI, EXEU: state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      JALR:   state_d = JAL;
      JAL:    state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.illegal    = 1'b0;

    case (opcode)
      OP_SW:                     bus.imm_src = 2'b01;
      OP_BR:                     bus.imm_src = 2'b10;
      OP_JAL, OP_LUI, OP_AUIPC:  bus.imm_src = 2'b11;
      default:                   bus.imm_src = 2'b00;
    endcase

    case (state_q)
      FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write   = 1'b1;
          bus.pc_write   = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
        end
      end
      DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ;
          default: bus.illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      MEMRD: begin
        bus.adr_src  = 1'b1;
        bus.mem_read = 1'b1;
      end
      MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      MEMWR: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      EXER: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
      end
      EXEI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
      end
      EXEU: begin
        bus.alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        bus.alu_src_b = 2'b01;
      end
      ALUWB: bus.reg_write = 1'b1;
      BRANCH: begin
        // Only beq/bne are decoded; funct3[0] inverts the sense of zero.
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        bus.pc_write  = bus.zero ^ funct3_lsb;
      end
      JALR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
      end
      default: ;
    endcase

    // Reset overrides combinationally so an in-flight store drops in the same cycle.
    if (rst) begin
      bus.pc_write   = 1'b0;
      bus.adr_src    = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.result_src = 2'b00;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.imm_src    = 2'b00;
      bus.alu_op     = 2'b00;
      bus.illegal    = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  always_comb begin
    retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
             ((state_q == MEMWR) && bus.mem_ready);
    retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign retired_o = rst ? '0 : retired_q;
`else
  assign retired_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-cycle strobe checks against hand-written vectors.
module tb_multicycle_ctrl;
  localparam int CNT_W = 32;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] I_LW   = 32'h0000_2003;
  localparam logic [31:0] I_SW   = 32'h0000_2023;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_LUI  = 32'h0000_0037;
  localparam logic [31:0] I_ADDI = 32'h0000_0013;
  localparam logic [31:0] I_ADD  = 32'h0000_0033;
  localparam logic [31:0] I_ILL  = 32'h0000_007F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0] retired;
  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .retired_o (retired)
  );

  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, illegal, result_src, a, b, op}
  function automatic logic [14:0] ev(input logic pcw, adr, mrd, mwr, irw, rw, ill,
                                      input logic [1:0] rs, a, b, op);
    return {pcw, adr, mrd, mwr, irw, rw, ill, rs, a, b, op};
  endfunction

  localparam logic [14:0] V_ZERO   = 15'h0;
  localparam logic [14:0] V_FWAIT  = ev(0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00);
  localparam logic [14:0] V_FRDY   = ev(1,0,1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00);
  localparam logic [14:0] V_DEC    = ev(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00);
  localparam logic [14:0] V_DECILL = ev(0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 2'b00);
  localparam logic [14:0] V_MEMADR = ev(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00);
  localparam logic [14:0] V_MEMRD  = ev(0,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00);
  localparam logic [14:0] V_MEMWB  = ev(0,0,0,0,0,1,0, 2'b01, 2'b00, 2'b00, 2'b00);
  localparam logic [14:0] V_MEMWR  = ev(0,1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00);
  localparam logic [14:0] V_EXER   = ev(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10);
  localparam logic [14:0] V_EXEI   = ev(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10);
  localparam logic [14:0] V_LUI    = ev(0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b01, 2'b00);
  localparam logic [14:0] V_ALUWB  = ev(0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00);
  localparam logic [14:0] V_BRT    = ev(1,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01);
  localparam logic [14:0] V_BRN    = ev(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01);
  localparam logic [14:0] V_JALR   = ev(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00);
  localparam logic [14:0] V_JAL    = ev(1,0,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00);

  function automatic logic [14:0] obs();
    return {bus.pc_write, bus.adr_src, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_write, bus.illegal, bus.result_src, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic cyc(input logic r, input logic [31:0] ins, input logic z, input logic rdy);
    @(posedge clk);
    #1;
    rst = r;
    bus.instr = ins;
    bus.zero = z;
    bus.mem_ready = rdy;
    #1;
  endtask

  function automatic logic [31:0] ret(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    bus.instr = I_LW; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    cyc(1, I_LW, 0, 1);
    chk("reset_out", 32'(obs()), 32'(V_ZERO));
    chk("reset_imm", 32'(bus.imm_src), 32'd0);
    chk("reset_retired", retired, 32'd0);

    // lw: two FETCH waits, one MEMRD wait
    cyc(0, I_LW, 0, 0); chk("lw_fetch_w1", 32'(obs()), 32'(V_FWAIT));
    chk("lw_imm", 32'(bus.imm_src), 32'd0);
    cyc(0, I_LW, 0, 0); chk("lw_fetch_w2", 32'(obs()), 32'(V_FWAIT));
    cyc(0, I_LW, 0, 1); chk("lw_fetch", 32'(obs()), 32'(V_FRDY));
    cyc(0, I_LW, 0, 0); chk("lw_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_LW, 0, 0); chk("lw_memadr", 32'(obs()), 32'(V_MEMADR));
    cyc(0, I_LW, 0, 0); chk("lw_memrd_w", 32'(obs()), 32'(V_MEMRD));
    cyc(0, I_LW, 0, 1); chk("lw_memrd", 32'(obs()), 32'(V_MEMRD));
    cyc(0, I_LW, 0, 0); chk("lw_memwb", 32'(obs()), 32'(V_MEMWB));

    // sw, zero wait
    cyc(0, I_SW, 0, 1); chk("sw_fetch", 32'(obs()), 32'(V_FRDY));
    chk("sw_imm_f", 32'(bus.imm_src), 32'd1);
    chk("retired_lw", retired, ret(1));
    cyc(0, I_SW, 0, 1); chk("sw_decode", 32'(obs()), 32'(V_DEC));
    chk("sw_imm_d", 32'(bus.imm_src), 32'd1);
    cyc(0, I_SW, 0, 1); chk("sw_memadr", 32'(obs()), 32'(V_MEMADR));
    cyc(0, I_SW, 0, 1); chk("sw_memwr", 32'(obs()), 32'(V_MEMWR));
    chk("sw_imm_w", 32'(bus.imm_src), 32'd1);

    // beq taken / not taken, bne taken / not taken
    cyc(0, I_BEQ, 1, 1); chk("beq_fetch", 32'(obs()), 32'(V_FRDY));
    chk("retired_sw", retired, ret(2));
    cyc(0, I_BEQ, 1, 1); chk("beq_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_BEQ, 1, 1); chk("beq_taken", 32'(obs()), 32'(V_BRT));
    chk("beq_imm", 32'(bus.imm_src), 32'd2);
    cyc(0, I_BEQ, 0, 1); chk("beq2_fetch", 32'(obs()), 32'(V_FRDY));
    cyc(0, I_BEQ, 0, 1); chk("beq2_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_BEQ, 0, 1); chk("beq_not_taken", 32'(obs()), 32'(V_BRN));
    cyc(0, I_BNE, 0, 1); chk("bne_fetch", 32'(obs()), 32'(V_FRDY));
    cyc(0, I_BNE, 0, 1); chk("bne_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_BNE, 0, 1); chk("bne_taken", 32'(obs()), 32'(V_BRT));
    cyc(0, I_BNE, 1, 1); chk("bne2_fetch", 32'(obs()), 32'(V_FRDY));
    cyc(0, I_BNE, 1, 1); chk("bne2_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_BNE, 1, 1); chk("bne_not_taken", 32'(obs()), 32'(V_BRN));

    // jal then jalr
    cyc(0, I_JAL, 0, 1); chk("jal_fetch", 32'(obs()), 32'(V_FRDY));
    chk("retired_br", retired, ret(6));
    chk("jal_imm", 32'(bus.imm_src), 32'd3);
    cyc(0, I_JAL, 0, 1); chk("jal_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_JAL, 0, 1); chk("jal_jal", 32'(obs()), 32'(V_JAL));
    cyc(0, I_JAL, 0, 1); chk("jal_aluwb", 32'(obs()), 32'(V_ALUWB));
    cyc(0, I_JALR, 0, 1); chk("jalr_fetch", 32'(obs()), 32'(V_FRDY));
    chk("jalr_imm", 32'(bus.imm_src), 32'd0);
    cyc(0, I_JALR, 0, 1); chk("jalr_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_JALR, 0, 1); chk("jalr_jalr", 32'(obs()), 32'(V_JALR));
    cyc(0, I_JALR, 0, 1); chk("jalr_jal", 32'(obs()), 32'(V_JAL));
    cyc(0, I_JALR, 0, 1); chk("jalr_aluwb", 32'(obs()), 32'(V_ALUWB));

    // illegal opcode: one-cycle pulse, back to FETCH, no retire
    cyc(0, I_ILL, 0, 1); chk("ill_fetch", 32'(obs()), 32'(V_FRDY));
    chk("retired_jmp", retired, ret(8));
    cyc(0, I_ILL, 0, 0); chk("ill_decode", 32'(obs()), 32'(V_DECILL));
    cyc(0, I_ILL, 0, 0); chk("ill_back_fetch", 32'(obs()), 32'(V_FWAIT));
    chk("retired_ill", retired, ret(8));

    // lui and R-type
    cyc(0, I_LUI, 0, 1); chk("lui_fetch", 32'(obs()), 32'(V_FRDY));
    chk("lui_imm", 32'(bus.imm_src), 32'd3);
    cyc(0, I_LUI, 0, 1); chk("lui_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_LUI, 0, 1); chk("lui_exeu", 32'(obs()), 32'(V_LUI));
    cyc(0, I_LUI, 0, 1); chk("lui_aluwb", 32'(obs()), 32'(V_ALUWB));
    cyc(0, I_ADD, 0, 1); chk("add_fetch", 32'(obs()), 32'(V_FRDY));
    cyc(0, I_ADD, 0, 1); chk("add_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_ADD, 0, 1); chk("add_exer", 32'(obs()), 32'(V_EXER));
    cyc(0, I_ADD, 0, 1); chk("add_aluwb", 32'(obs()), 32'(V_ALUWB));

    // reset during a stalled store
    cyc(0, I_SW, 0, 1); chk("swr_fetch", 32'(obs()), 32'(V_FRDY));
    chk("retired_alu", retired, ret(10));
    cyc(0, I_SW, 0, 1); chk("swr_decode", 32'(obs()), 32'(V_DEC));
    cyc(0, I_SW, 0, 1); chk("swr_memadr", 32'(obs()), 32'(V_MEMADR));
    cyc(0, I_SW, 0, 0); chk("swr_memwr_w", 32'(obs()), 32'(V_MEMWR));
    cyc(1, I_SW, 0, 0); chk("swr_rst_same", 32'(obs()), 32'(V_ZERO));
    cyc(0, I_SW, 0, 0); chk("swr_after_rst", 32'(obs()), 32'(V_FWAIT));
    chk("retired_rst", retired, 32'd0);

    // three back-to-back addi
    for (int k = 0; k < 3; k++) begin
      cyc(0, I_ADDI, 0, 1); chk("addi_fetch", 32'(obs()), 32'(V_FRDY));
      cyc(0, I_ADDI, 0, 1); chk("addi_decode", 32'(obs()), 32'(V_DEC));
      cyc(0, I_ADDI, 0, 1); chk("addi_exei", 32'(obs()), 32'(V_EXEI));
      cyc(0, I_ADDI, 0, 1); chk("addi_aluwb", 32'(obs()), 32'(V_ALUWB));
    end
    cyc(0, I_ADDI, 0, 0); chk("addi_end_fetch", 32'(obs()), 32'(V_FWAIT));
    chk("retired_addi", retired, ret(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
